alu_operand_fetch: RTL and testbench
====================================

ALU_OPERAND_FETCH -- requirements
Module: alu_operand_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning pending-issue FIFO entries (power of 2, >=2).
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  discard all pending and staged ops.
REQ-005 SHALL have port issue_valid  input  1  RS presents an issued op.
REQ-006 SHALL have port issue_op  input  of_entry_t  {aluop_t op, phys_reg_tag_t dest, src0, src1}.
REQ-007 SHALL have port issue_ready  output  1  FIFO can accept an op this cycle.
REQ-008 SHALL have port read_req_valid  output  1  operand read request to register file.
REQ-009 SHALL have ports read_req_0_tag, read_req_1_tag  output  phys_reg_tag_t  head src0/src1 tags.
REQ-010 SHALL have port read_req_serviced  input  1  register file granted this cycle.
REQ-011 SHALL have ports read_bus_0_data, read_bus_1_data  input  word_t  same-cycle read data.
REQ-012 SHALL have port out_valid  output  1  staged op with operands valid.
REQ-013 SHALL have ports out_op (aluop_t), out_dest (phys_reg_tag_t), out_a, out_b (word_t)  output  staged op fields.
REQ-014 SHALL have port out_ready  input  1  ALU consumes staged op.
REQ-015 SHALL have port stall_count  output  16  saturating count of unserviced request cycles.

Function
REQ-016 SHALL push issue_op into FIFO when issue_valid && issue_ready && !flush; issue_ready = !full (no push-through on pop).
REQ-017 SHALL assert read_req_valid only when FIFO non-empty and stage can accept (out_valid==0 or out_ready==1) and flush==0.
REQ-018 SHALL drive read_req_0/1_tag from FIFO head src0/src1 combinationally whenever FIFO non-empty.
REQ-019 SHALL, on read_req_valid && read_req_serviced, pop head and load stage with head op/dest and read_bus_0/1_data at that posedge (latency: grant cycle -> out_valid next cycle).
REQ-020 SHALL hold FIFO head and tags unchanged while read_req_valid && !read_req_serviced (retry every cycle, no timeout).
REQ-021 SHALL ignore read_req_serviced when read_req_valid==0.
REQ-022 SHALL clear out_valid at posedge when out_valid && out_ready and no new load; a load with out_ready==1 replaces stage (back-to-back throughput 1/cycle).
REQ-023 SHALL hold stage contents stable while out_valid && !out_ready.
REQ-024 SHALL allow simultaneous push and pop when not full; occupancy unchanged; pointers wrap modulo DEPTH.
REQ-025 SHALL on flush: empty FIFO, clear out_valid, drop same-cycle issue and grant; flush has priority over all events.
REQ-026 SHALL increment stall_count when read_req_valid && !read_req_serviced, saturating at 16'hFFFF; flush does not clear it.
REQ-027 SHALL perform no writes to the register file and never request phys reg 0 specially (tag passed as issued).

Reset
REQ-028 SHALL on RST=1 at posedge: FIFO empty, pointers 0, out_valid=0, out_op/out_dest/out_a/out_b=0, stall_count=0.
REQ-029 SHALL, with RST asserted, hold read_req_valid=0 and issue_ready=1 combinationally on the following cycles; RST mid-transfer discards pending ops without a grant.

Structure
REQ-030 SHALL take phys_reg_tag_t, word_t, aluop_t from core_types_pkg; of_entry_t SHALL be added to core_types_pkg.
REQ-031 SHALL implement the pending queue as sub-module of_fifo (DEPTH-parameterised, push/pop/full/empty, head output); staging and counter in the top.

Verification
REQ-032 SHALL cover: issue {op=ADD,dest=5,src0=3,src1=4}, serviced=1 same cycle, bus=32'h11/32'h22 -> next cycle out_valid=1, out_a=32'h11, out_b=32'h22, out_dest=5.
REQ-033 SHALL cover: 4 issues with serviced=0 for 3 cycles -> tags hold 3/4, issue_ready=0 after 4th push, stall_count=3, then serviced=1 pops in order.
REQ-034 SHALL cover: out_ready=0 with staged op and FIFO non-empty -> read_req_valid=0; out_ready=1 -> read_req_valid=1 same cycle.
REQ-035 SHALL cover: 10 back-to-back issues with serviced=1, out_ready=1 -> 10 outputs in 10 consecutive cycles, order preserved across pointer wrap.
REQ-036 SHALL cover: flush concurrent with issue_valid and serviced=1 -> next cycle FIFO empty, out_valid=0, stall_count unchanged.
REQ-037 SHALL cover: RST asserted with 3 pending and stall_count=7 -> next cycle all outputs 0, issue_ready=1.

Source files
------------

// File: rtl/core_types_pkg.sv
// core_types_pkg: shared core types for the ALU operand-fetch path
package core_types_pkg;
   typedef logic [5:0]  phys_reg_tag_t;
   typedef logic [31:0] word_t;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
   } aluop_t;
   typedef struct packed {
      aluop_t        op;
      phys_reg_tag_t dest;
      phys_reg_tag_t src0;
      phys_reg_tag_t src1;
   } of_entry_t;
endpackage

// File: rtl/of_fifo.sv
// of_fifo: pending-issue queue of ops waiting for register-file operands
module of_fifo
   import core_types_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      i_clr,
   input  logic      i_push,
   input  logic      i_pop,
   input  of_entry_t i_din,
   output of_entry_t o_head,
   output logic      o_full,
   output logic      o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   of_entry_t     r_mem [DEPTH];
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end
   // storage needs no reset: occupancy alone says what is valid
   always_ff @(posedge clk)
      if (i_push) r_mem[r_wr_ptr] <= i_din;
   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = r_count == (AW+1)'(DEPTH);
   assign o_empty = r_count == '0;
endmodule

// File: rtl/alu_operand_fetch.sv
// alu_operand_fetch: queues issued ops, reads their operands from the
// register file and stages the op plus operands for the ALU
module alu_operand_fetch
   import core_types_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          flush,
   input  logic          issue_valid,
   input  of_entry_t     issue_op,
   output logic          issue_ready,
   output logic          read_req_valid,
   output phys_reg_tag_t read_req_0_tag,
   output phys_reg_tag_t read_req_1_tag,
   input  logic          read_req_serviced,
   input  word_t         read_bus_0_data,
   input  word_t         read_bus_1_data,
   output logic          out_valid,
   output aluop_t        out_op,
   output phys_reg_tag_t out_dest,
   output word_t         out_a,
   output word_t         out_b,
   input  logic          out_ready,
   output logic [15:0]   stall_count
);
   logic          w_full, w_empty, w_push, w_grant;
   of_entry_t     w_head;
   logic          r_out_valid;
   aluop_t        r_out_op;
   phys_reg_tag_t r_out_dest;
   word_t         r_out_a, r_out_b;
   logic [15:0]   r_stall;
   assign issue_ready    = RST || !w_full;
   assign read_req_valid = !RST && !flush && !w_empty && (!r_out_valid || out_ready);
   assign w_grant        = read_req_valid && read_req_serviced;
   assign w_push         = issue_valid && issue_ready && !flush;
   assign read_req_0_tag = w_empty ? '0 : w_head.src0;
   assign read_req_1_tag = w_empty ? '0 : w_head.src1;
   of_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (CLK),
      .rst    (RST),
      .i_clr  (flush),
      .i_push (w_push),
      .i_pop  (w_grant),
      .i_din  (issue_op),
      .o_head (w_head),
      .o_full (w_full),
      .o_empty(w_empty)
   );
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_out_valid <= 1'b0;
         r_out_op    <= ALU_ADD;
         r_out_dest  <= '0;
         r_out_a     <= '0;
         r_out_b     <= '0;
         r_stall     <= '0;
      end else begin
         if (flush) r_out_valid <= 1'b0;
         else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_op    <= w_head.op;
            r_out_dest  <= w_head.dest;
            r_out_a     <= read_bus_0_data;
            r_out_b     <= read_bus_1_data;
         end else if (out_ready) r_out_valid <= 1'b0;
         if (read_req_valid && !read_req_serviced && r_stall != '1) r_stall <= r_stall + 16'd1;
      end
   end
   assign out_valid   = r_out_valid;
   assign out_op      = r_out_op;
   assign out_dest    = r_out_dest;
   assign out_a       = r_out_a;
   assign out_b       = r_out_b;
   assign stall_count = r_stall;
endmodule

// File: tb/tb_alu_operand_fetch.sv
// tb_alu_operand_fetch: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the operand-fetch stage
module tb_alu_operand_fetch;
   import core_types_pkg::*;
   localparam int DEPTH = 4;
   logic          CLK = 0, RST = 1, flush = 0, issue_valid = 0, read_req_serviced = 0, out_ready = 0;
   of_entry_t     issue_op = '0;
   word_t         bus0 = '0, bus1 = '0;
   logic          issue_ready, read_req_valid, out_valid;
   phys_reg_tag_t tag0, tag1, out_dest;
   aluop_t        out_op;
   word_t         out_a, out_b;
   logic [15:0]   stall_count;
   int            n_checks = 0, n_err = 0;
   of_entry_t     q[$];
   logic          m_sv = 0;
   of_entry_t     m_st = '0;
   word_t         m_a = '0, m_b = '0;
   int            m_stall = 0;

   alu_operand_fetch #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .flush(flush), .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_ready(issue_ready), .read_req_valid(read_req_valid), .read_req_0_tag(tag0),
      .read_req_1_tag(tag1), .read_req_serviced(read_req_serviced), .read_bus_0_data(bus0),
      .read_bus_1_data(bus1), .out_valid(out_valid), .out_op(out_op), .out_dest(out_dest),
      .out_a(out_a), .out_b(out_b), .out_ready(out_ready), .stall_count(stall_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic of_entry_t mk(input aluop_t op, input int d, input int s0, input int s1);
      of_entry_t e;
      e.op = op; e.dest = 6'(d); e.src0 = 6'(s0); e.src1 = 6'(s1);
      return e;
   endfunction

   // model: inputs are stable from posedge+1 through the next posedge, so the
   // negedge both checks the current cycle and computes the next state
   always @(negedge CLK) begin
      logic e_rrv, e_ir, grant;
      e_rrv = !RST && !flush && q.size() > 0 && (!m_sv || out_ready);
      e_ir  = RST || q.size() < DEPTH;
      check("issue_ready", 32'(issue_ready), 32'(e_ir));
      check("read_req_valid", 32'(read_req_valid), 32'(e_rrv));
      check("out_valid", 32'(out_valid), 32'(m_sv));
      check("stall_count", 32'(stall_count), 32'(m_stall));
      if (q.size() > 0) begin
         check("tag0", 32'(tag0), 32'(q[0].src0));
         check("tag1", 32'(tag1), 32'(q[0].src1));
      end
      if (m_sv) begin
         check("out_op", 32'(out_op), 32'(m_st.op));
         check("out_dest", 32'(out_dest), 32'(m_st.dest));
         check("out_a", out_a, m_a);
         check("out_b", out_b, m_b);
      end
      if (RST) begin
         q.delete(); m_sv = 0; m_st = '0; m_a = '0; m_b = '0; m_stall = 0;
      end else if (flush) begin
         q.delete(); m_sv = 0;
      end else begin
         grant = e_rrv && read_req_serviced;
         if (e_rrv && !read_req_serviced && m_stall < 65535) m_stall++;
         if (grant) begin
            m_st = q.pop_front(); m_a = bus0; m_b = bus1; m_sv = 1;
         end else if (out_ready) m_sv = 0;
         if (issue_valid && e_ir) q.push_back(issue_op);
      end
   end

   initial begin
      out_ready = 1;
      repeat (2) step();
      RST = 0;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_stall", 32'(stall_count), 0);
      check("rst_issue_ready", 32'(issue_ready), 1);
      // single op, granted as soon as it reaches the head
      issue_valid = 1; issue_op = mk(ALU_ADD, 5, 3, 4);
      read_req_serviced = 1; bus0 = 32'h11; bus1 = 32'h22;
      step();
      issue_valid = 0;
      step();
      check("single_valid", 32'(out_valid), 1);
      check("single_a", out_a, 32'h11);
      check("single_b", out_b, 32'h22);
      check("single_dest", 32'(out_dest), 5);
      check("single_op", 32'(out_op), 32'(ALU_ADD));
      step();
      // fill while the register file refuses
      read_req_serviced = 0;
      for (int i = 0; i < 4; i++) begin
         issue_valid = 1;
         issue_op = mk(aluop_t'(4'(i)), 20 + i, i == 0 ? 3 : 30 + i, i == 0 ? 4 : 40 + i);
         step();
      end
      issue_valid = 0;
      check("full_issue_ready", 32'(issue_ready), 0);
      check("full_stall", 32'(stall_count), 3);
      check("full_tag0", 32'(tag0), 3);
      check("full_tag1", 32'(tag1), 4);
      read_req_serviced = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("drain_valid", 32'(out_valid), 1);
         check("drain_dest", 32'(out_dest), 32'(20 + i));
      end
      step();
      // staged op blocked by the ALU gates new requests
      out_ready = 0; issue_valid = 1; issue_op = mk(ALU_SUB, 7, 1, 2);
      step();
      issue_op = mk(ALU_OR, 8, 5, 6);
      step();
      issue_valid = 0;
      step();
      check("block_valid", 32'(out_valid), 1);
      check("block_dest", 32'(out_dest), 7);
      check("block_rrv", 32'(read_req_valid), 0);
      out_ready = 1;
      #1;
      check("unblock_rrv", 32'(read_req_valid), 1);
      check("unblock_tag0", 32'(tag0), 5);
      step(); step();
      // ten back-to-back ops across pointer wrap
      for (int i = 0; i < 10; i++) begin
         issue_valid = 1; issue_op = mk(aluop_t'(4'(i % 8)), 10 + i, i, i + 1);
         bus0 = 32'(i * 3); bus1 = 32'(i * 5);
         step();
         if (i >= 1) begin
            check("stream_valid", 32'(out_valid), 1);
            check("stream_dest", 32'(out_dest), 32'(9 + i));
         end
      end
      issue_valid = 0;
      step();
      check("stream_last_valid", 32'(out_valid), 1);
      check("stream_last_dest", 32'(out_dest), 19);
      step();
      // flush beats a concurrent issue and grant
      read_req_serviced = 0; issue_valid = 1; issue_op = mk(ALU_XOR, 9, 11, 12);
      step();
      issue_valid = 0;
      step();
      flush = 1; issue_valid = 1; issue_op = mk(ALU_AND, 13, 14, 15); read_req_serviced = 1;
      step();
      flush = 0; issue_valid = 0; read_req_serviced = 0;
      check("flush_valid", 32'(out_valid), 0);
      check("flush_rrv", 32'(read_req_valid), 0);
      check("flush_stall", 32'(stall_count), 4);
      check("flush_issue_ready", 32'(issue_ready), 1);
      // reset with pending ops and a non-zero stall count
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1; issue_op = mk(ALU_SLL, 40 + i, 50 + i, 60 + i);
         step();
      end
      issue_valid = 0;
      step();
      check("pre_rst_stall", 32'(stall_count), 7);
      RST = 1;
      step();
      check("rst2_valid", 32'(out_valid), 0);
      check("rst2_op", 32'(out_op), 0);
      check("rst2_dest", 32'(out_dest), 0);
      check("rst2_a", out_a, 0);
      check("rst2_b", out_b, 0);
      check("rst2_stall", 32'(stall_count), 0);
      check("rst2_rrv", 32'(read_req_valid), 0);
      check("rst2_issue_ready", 32'(issue_ready), 1);
      RST = 0;
      // random traffic
      for (int c = 0; c < 1500; c++) begin
         issue_valid = $urandom_range(0, 2) != 0;
         issue_op = mk(aluop_t'(4'($urandom_range(0, 7))), $urandom, $urandom, $urandom);
         read_req_serviced = $urandom_range(0, 9) < 6;
         out_ready = $urandom_range(0, 3) != 0;
         flush = $urandom_range(0, 40) == 0;
         RST = $urandom_range(0, 150) == 0;
         bus0 = $urandom; bus1 = $urandom;
         step();
      end
      issue_valid = 0; flush = 0; RST = 0;
      step();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
